vga_tft_timing_gen: RTL and testbench

- Parametrised VGA/TFT raster engine; next generation of the fixed-resolution VGA_TFT controller.
- Generates HS/VS/BLK (BLK = data-enable) timing and RGB565 pixels, and requests pixel data from an external source with one-cycle read latency (BRAM or framebuffer).
- Built-in test patterns. Backlight gated until the raster is stable.
- Sits between the pixel-clock domain framebuffer and the TFT/VGA pins.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_axis_counter.sv | 40 ++++
 rtl/vga_tft_timing_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_vga_tft_timing_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA/TFT raster engine: pattern modes, bar colours, timing helpers.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic int axis_total(input int sync_len, input int back_len,
                                      input int active_len, input int front_len);
        return sync_len + back_len + active_len + front_len;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with wrap flag and sync/active region decode.
// Regions are decoded combinationally from the current count; wrap is only flagged while enabled.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int SYNC   = 128,
    parameter int BACK   = 88,
    parameter int ACTIVE = 800,
    parameter int FRONT  = 40,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int TOTAL = axis_total(SYNC, BACK, ACTIVE, FRONT);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BACK);
    localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BACK + ACTIVE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign wrap   = en && (cnt == LAST);
    assign sync   = (cnt < SYNC_END);
    assign active = (cnt >= ACT_LO) && (cnt < ACT_HI);

endmodule

// File: rtl/vga_tft_timing_gen.sv
// Parametrised VGA/TFT raster engine: HS/VS/BLK timing, RGB565 test patterns and external pixel fetch.
// Fixed 3-cycle counter-to-pin latency; the external source answers Data_Req one cycle later.
module vga_tft_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC          = 128,
    parameter int H_BACK          = 88,
    parameter int H_ACTIVE        = 800,
    parameter int H_FRONT         = 40,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 10,
    parameter int HS_POL          = 0,
    parameter int VS_POL          = 0,
    parameter int GRID_LOG2       = 5,
    parameter int BL_DELAY_FRAMES = 2,
    parameter int CNT_W           = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Mode,
    input  logic [15:0]      Solid_Color,
    output logic             Data_Req,
    output logic [CNT_W-1:0] Req_X,
    output logic [CNT_W-1:0] Req_Y,
    input  logic [15:0]      Data_In,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLK,
    output logic [15:0]      VGA_RGB,
    output logic [CNT_W-1:0] Pixel_X,
    output logic [CNT_W-1:0] Pixel_Y,
    output logic             Frame_Start,
    output logic             TFT_BL
);

    localparam logic             HS_LVL   = 1'(HS_POL);
    localparam logic             VS_LVL   = 1'(VS_POL);
    localparam logic [CNT_W-1:0] H_OFS    = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_OFS    = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
    localparam int               FC_W     = $clog2(BL_DELAY_FRAMES + 1) + 1;
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(BL_DELAY_FRAMES);

    logic [CNT_W-1:0] hc, vc;
    logic             h_wrap, v_wrap;
    logic             h_sync, v_sync;
    logic             h_act, v_act;
    logic             pixel_act;

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .CNT_W  (CNT_W)
    ) u_h (
        .clk    (Clk),
        .reset  (Reset),
        .en     (1'b1),
        .cnt    (hc),
        .wrap   (h_wrap),
        .sync   (h_sync),
        .active (h_act)
    );

    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .CNT_W  (CNT_W)
    ) u_v (
        .clk    (Clk),
        .reset  (Reset),
        .en     (h_wrap),
        .cnt    (vc),
        .wrap   (v_wrap),
        .sync   (v_sync),
        .active (v_act)
    );

    assign pixel_act = h_act && v_act;

    // High exactly while hc == 0 and vc == 0: that state follows reset or a frame wrap.
    logic frame_origin;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_origin <= 1'b1;
        end else begin
            frame_origin <= v_wrap;
        end
    end

    mode_e       mode_q;
    logic [15:0] solid_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode_q  <= MODE_EXT;
            solid_q <= '0;
        end else if (frame_origin) begin
            mode_q  <= mode_e'(Mode);
            solid_q <= Solid_Color;
        end
    end

    logic             s1_hs, s1_vs, s1_act, s1_fs, req_q;
    logic [CNT_W-1:0] s1_x, s1_y;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_act <= 1'b0;
            s1_fs  <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
            req_q  <= 1'b0;
        end else begin
            s1_hs  <= h_sync;
            s1_vs  <= v_sync;
            s1_act <= pixel_act;
            s1_fs  <= frame_origin;
            s1_x   <= pixel_act ? hc - H_OFS : '0;
            s1_y   <= pixel_act ? vc - V_OFS : '0;
            req_q  <= pixel_act && (mode_q == MODE_EXT);
        end
    end

    assign Data_Req = req_q;
    assign Req_X    = s1_x;
    assign Req_Y    = s1_y;

    logic             s2_hs, s2_vs, s2_act, s2_fs;
    logic [CNT_W-1:0] s2_x, s2_y;
    logic [CNT_W-1:0] bar_sub;
    logic [2:0]       bar_idx;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_act <= 1'b0;
            s2_fs  <= 1'b0;
            s2_x   <= '0;
            s2_y   <= '0;
        end else begin
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_act <= s1_act;
            s2_fs  <= s1_fs;
            s2_x   <= s1_x;
            s2_y   <= s1_y;
        end
    end

    // Bar index tracks s2_x; it restarts on the first active pixel of each line.
    always_ff @(posedge Clk) begin
        if (Reset || !(s1_act && s2_act)) begin
            bar_sub <= '0;
            bar_idx <= '0;
        end else if (bar_sub == BAR_LAST) begin
            bar_sub <= '0;
            bar_idx <= bar_idx + 1'b1;
        end else begin
            bar_sub <= bar_sub + 1'b1;
        end
    end

    logic [15:0] pix_rgb;

    always_comb begin
        pix_rgb = RGB_BLACK;
        if (s2_act) begin
            case (mode_q)
                MODE_EXT:   pix_rgb = Data_In;
                MODE_BARS:  pix_rgb = bar_color(bar_idx);
                MODE_GRID:  pix_rgb = ((s2_x[GRID_LOG2-1:0] == '0) || (s2_y[GRID_LOG2-1:0] == '0))
                                      ? RGB_WHITE : RGB_BLACK;
                default:    pix_rgb = solid_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_HS      <= ~HS_LVL;
            VGA_VS      <= ~VS_LVL;
            VGA_BLK     <= 1'b0;
            VGA_RGB     <= '0;
            Pixel_X     <= '0;
            Pixel_Y     <= '0;
            Frame_Start <= 1'b0;
        end else begin
            VGA_HS      <= s2_hs ? HS_LVL : ~HS_LVL;
            VGA_VS      <= s2_vs ? VS_LVL : ~VS_LVL;
            VGA_BLK     <= s2_act;
            VGA_RGB     <= pix_rgb;
            Pixel_X     <= s2_x;
            Pixel_Y     <= s2_y;
            Frame_Start <= s2_fs;
        end
    end

    logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;

    always_comb begin
        frame_cnt_nxt = frame_cnt;
        if (Frame_Start && (frame_cnt != FC_MAX)) begin
            frame_cnt_nxt = frame_cnt + 1'b1;
        end
    end

    // Looking at the next count lets the backlight rise the cycle after the final pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt <= '0;
            TFT_BL    <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            TFT_BL    <= TFT_BL | (frame_cnt_nxt == FC_MAX);
        end
    end

endmodule

// File: tb/tb_vga_tft_timing_gen.sv
// Scoreboard bench: a behavioural raster model queues expected pin values, compared as the DUTs emit them.
module tb_vga_tft_timing_gen;

    localparam int P_HSYNC = 4, P_HBACK = 2, P_HACT = 16, P_HFRONT = 2;
    localparam int P_VSYNC = 2, P_VBACK = 1, P_VACT = 8, P_VFRONT = 1;
    localparam int HT = P_HSYNC + P_HBACK + P_HACT + P_HFRONT;
    localparam int VT = P_VSYNC + P_VBACK + P_VACT + P_VFRONT;
    localparam int FT = HT * VT;
    localparam int CW = 12;
    localparam int BLD = 2;
    localparam logic [43:0] IDLE = {1'b1, 1'b1, 42'h0};

    logic          Clk = 1'b0;
    logic          Reset;
    logic [1:0]    Mode;
    logic [15:0]   Solid_Color;
    logic [15:0]   Data_In;

    logic          Data_Req0, Data_Req1;
    logic [CW-1:0] Req_X0, Req_Y0, Req_X1, Req_Y1;
    logic          VGA_HS0, VGA_VS0, VGA_BLK0, VGA_HS1, VGA_VS1, VGA_BLK1;
    logic [15:0]   VGA_RGB0, VGA_RGB1;
    logic [CW-1:0] Pixel_X0, Pixel_Y0, Pixel_X1, Pixel_Y1;
    logic          Frame_Start0, Frame_Start1, TFT_BL0, TFT_BL1;

    always #5 Clk = ~Clk;

    vga_tft_timing_gen #(
        .H_SYNC(P_HSYNC), .H_BACK(P_HBACK), .H_ACTIVE(P_HACT), .H_FRONT(P_HFRONT),
        .V_SYNC(P_VSYNC), .V_BACK(P_VBACK), .V_ACTIVE(P_VACT), .V_FRONT(P_VFRONT),
        .HS_POL(0), .VS_POL(0), .GRID_LOG2(2), .BL_DELAY_FRAMES(BLD), .CNT_W(CW)
    ) dut0 (
        .Clk(Clk), .Reset(Reset), .Mode(Mode), .Solid_Color(Solid_Color),
        .Data_Req(Data_Req0), .Req_X(Req_X0), .Req_Y(Req_Y0), .Data_In(Data_In),
        .VGA_HS(VGA_HS0), .VGA_VS(VGA_VS0), .VGA_BLK(VGA_BLK0), .VGA_RGB(VGA_RGB0),
        .Pixel_X(Pixel_X0), .Pixel_Y(Pixel_Y0), .Frame_Start(Frame_Start0), .TFT_BL(TFT_BL0)
    );

    vga_tft_timing_gen #(
        .H_SYNC(P_HSYNC), .H_BACK(P_HBACK), .H_ACTIVE(P_HACT), .H_FRONT(P_HFRONT),
        .V_SYNC(P_VSYNC), .V_BACK(P_VBACK), .V_ACTIVE(P_VACT), .V_FRONT(P_VFRONT),
        .HS_POL(1), .VS_POL(1), .GRID_LOG2(2), .BL_DELAY_FRAMES(BLD), .CNT_W(CW)
    ) dut1 (
        .Clk(Clk), .Reset(Reset), .Mode(Mode), .Solid_Color(Solid_Color),
        .Data_Req(Data_Req1), .Req_X(Req_X1), .Req_Y(Req_Y1), .Data_In(Data_In),
        .VGA_HS(VGA_HS1), .VGA_VS(VGA_VS1), .VGA_BLK(VGA_BLK1), .VGA_RGB(VGA_RGB1),
        .Pixel_X(Pixel_X1), .Pixel_Y(Pixel_Y1), .Frame_Start(Frame_Start1), .TFT_BL(TFT_BL1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Record layout: {hs, vs, blk, frame_start, rgb[15:0], x[11:0], y[11:0]}
    logic [43:0] exp_q[$];
    logic [24:0] req_q[$];

    int          m_hc, m_vc, bl_cnt;
    logic [1:0]  m_mode;
    logic [15:0] m_solid;
    logic        m_bl;
    logic        armed = 1'b0;
    logic [15:0] pending = 16'hDEAD;

    function automatic logic [15:0] bar(input int idx);
        case (idx)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [43:0] model_rec(input int hc, input int vc,
                                              input logic [1:0] md, input logic [15:0] sc);
        logic        act;
        int          x, y;
        logic [15:0] rgb;
        act = (hc >= P_HSYNC + P_HBACK) && (hc < P_HSYNC + P_HBACK + P_HACT) &&
              (vc >= P_VSYNC + P_VBACK) && (vc < P_VSYNC + P_VBACK + P_VACT);
        x   = act ? hc - (P_HSYNC + P_HBACK) : 0;
        y   = act ? vc - (P_VSYNC + P_VBACK) : 0;
        rgb = 16'h0000;
        if (act) begin
            case (md)
                2'd0:    rgb = {4'h0, 4'(y), 8'(x)};
                2'd1:    rgb = bar(x / (P_HACT / 8));
                2'd2:    rgb = ((x % 4) == 0 || (y % 4) == 0) ? 16'hFFFF : 16'h0000;
                default: rgb = sc;
            endcase
        end
        return {hc >= P_HSYNC, vc >= P_VSYNC, act, (hc == 0 && vc == 0), rgb, 12'(x), 12'(y)};
    endfunction

    function automatic logic [1:0] mode_for(input int f);
        case (f)
            0: return 2'd1;
            1: return 2'd0;
            2: return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    task automatic step(input logic rst, input logic [1:0] md, input logic [15:0] sc);
        logic [43:0] e, rec;
        logic [24:0] r;
        logic        cur_fs;
        @(negedge Clk);
        cur_fs = 1'b0;
        if (armed && exp_q.size() > 0 && req_q.size() > 0) begin
            e = exp_q.pop_front();
            r = req_q.pop_front();
            cur_fs = e[40];
            check("video_pol0", 64'({VGA_HS0, VGA_VS0, VGA_BLK0, Frame_Start0, VGA_RGB0, Pixel_X0, Pixel_Y0}), 64'(e));
            check("video_pol1", 64'({VGA_HS1, VGA_VS1, VGA_BLK1, Frame_Start1, VGA_RGB1, Pixel_X1, Pixel_Y1}),
                  64'({~e[43:42], e[41:0]}));
            check("req0", 64'({Data_Req0, Req_X0, Req_Y0}), 64'(r));
            check("req1", 64'({Data_Req1, Req_X1, Req_Y1}), 64'(r));
            check("backlight", 64'({TFT_BL0, TFT_BL1}), 64'({m_bl, m_bl}));
        end
        // Source answers a request one cycle later.
        Data_In     = pending;
        pending     = Data_Req0 ? {4'h0, Req_Y0[3:0], Req_X0[7:0]} : 16'hDEAD;
        Reset       = rst;
        Mode        = md;
        Solid_Color = sc;
        if (rst) begin
            exp_q.delete();
            req_q.delete();
            repeat (3) exp_q.push_back(IDLE);
            req_q.push_back(25'h0);
            m_hc    = 0;
            m_vc    = 0;
            m_mode  = 2'd0;
            m_solid = 16'h0;
            bl_cnt  = 0;
            m_bl    = 1'b0;
            armed   = 1'b1;
        end else begin
            rec = model_rec(m_hc, m_vc, m_mode, m_solid);
            exp_q.push_back(rec);
            req_q.push_back({rec[41] && (m_mode == 2'd0), rec[23:0]});
            if (cur_fs && bl_cnt < BLD) bl_cnt++;
            m_bl = (bl_cnt == BLD);
            if (m_hc == 0 && m_vc == 0) begin
                m_mode  = md;
                m_solid = sc;
            end
            m_hc++;
            if (m_hc == HT) begin
                m_hc = 0;
                m_vc++;
                if (m_vc == VT) m_vc = 0;
            end
        end
    endtask

    initial begin
        Reset       = 1'b1;
        Mode        = 2'd1;
        Solid_Color = 16'h5A5A;
        Data_In     = 16'h0;
        repeat (3) step(1'b1, 2'd1, 16'h5A5A);
        // Frames: bars, external, solid (switched to grid mid-frame), grid; then reset mid-line.
        for (int c = 0; c < 4 * FT + 3 * HT + 12; c++) begin
            int f, pos;
            logic [1:0]  md;
            logic [15:0] sc;
            f   = c / FT;
            pos = c % FT;
            md  = (pos < ((f == 2) ? 5 * HT + 10 : 50)) ? mode_for(f) : mode_for(f + 1);
            sc  = (f == 2 && pos >= 100) ? 16'hC3C3 : 16'h5A5A;
            step(1'b0, md, sc);
        end
        step(1'b1, 2'd2, 16'h5A5A);
        for (int c = 0; c < 40; c++) step(1'b0, 2'd2, 16'h5A5A);
        step(1'b0, 2'd2, 16'h5A5A);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
